// File: rtl/crc32_fcs_stream_if.sv
// crc32_fcs_stream_if: valid/ready/last beat stream carrying DATA_W bits per beat.
interface crc32_fcs_stream_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic              ready;
  modport master(output data, valid, last, input ready);
  modport slave(input data, valid, last, output ready);
endinterface

// File: rtl/crc32_fcs_stream.sv
// crc32_fcs_stream: streaming reflected CRC-32 that appends the FCS or residue-checks a received frame.
module crc32_fcs_stream #(
  parameter int DATA_W     = 4,
  parameter bit APPEND_FCS = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  crc32_fcs_stream_if.slave  s,
  crc32_fcs_stream_if.master m,
  output logic [31:0]        crc_state,
  output logic               frame_done,
  output logic               fcs_ok
);
  localparam int N = 32 / DATA_W;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  typedef enum logic {DATA, FCS} state_t;
  state_t        state;
  logic [31:0]   crc_next;
  logic [31:0]   fcs_reg;
  logic [CW-1:0] cnt;
  logic          out_free;
  logic          xfer;
  always_comb begin
    crc_next = crc_state;
    for (int i = 0; i < DATA_W; i++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ s.data[i]) ? POLY : 32'h0);
  end
  assign out_free = !m.valid || m.ready;
  assign s.ready  = state == DATA && out_free;
  assign xfer     = s.valid && s.ready;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= DATA;
      cnt        <= '0;
      crc_state  <= '1;
      fcs_reg    <= '0;
      m.data     <= '0;
      m.valid    <= 1'b0;
      m.last     <= 1'b0;
      frame_done <= 1'b0;
      fcs_ok     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == DATA) begin
        if (xfer) begin
          m.data    <= s.data;
          m.valid   <= 1'b1;
          m.last    <= s.last && !APPEND_FCS;
          crc_state <= s.last ? '1 : crc_next;
          if (s.last) begin
            frame_done <= 1'b1;
            fcs_ok     <= crc_next == RESIDUE;
            if (APPEND_FCS) begin
              fcs_reg <= ~crc_next;
              cnt     <= '0;
              state   <= FCS;
            end
          end
        end else if (m.ready) begin
          m.valid <= 1'b0;
        end
      end else if (out_free) begin
        // FCS leaves LSB-first, one DATA_W chunk per beat
        m.data  <= fcs_reg[cnt*DATA_W +: DATA_W];
        m.valid <= 1'b1;
        m.last  <= cnt == LAST;
        cnt     <= cnt == LAST ? '0 : cnt + 1'b1;
        if (cnt == LAST) state <= DATA;
      end
    end
  end
endmodule

// File: doc/crc32_fcs_stream.md
Name: crc32_fcs_stream

Overview:
- Parametrised streaming IEEE 802.3/802.11 CRC-32 engine for the openwifi TX/RX datapath.
- Processes DATA_W bits per cycle over a valid/ready stream.
- TX mode: appends the 32-bit FCS after the last payload beat.
- Check mode: validates a received frame that already carries its FCS, using the residue test.
- Sits between the MAC payload source and the scrambler/encoder chain; check mode is reused on the RX side.

Parameters:
- DATA_W, 4, bits consumed per beat; legal values 1, 2, 4, 8 (32 % DATA_W == 0).
- APPEND_FCS, 1, 1 = emit FCS after s_last beat; 0 = pass-through plus residue check only.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  synchronous active-low reset.
- s_data  in  DATA_W  input payload beat; bit 0 is first on air.
- s_valid  in  1  input beat valid.
- s_last  in  1  marks the final input beat of a frame.
- s_ready  out  1  block accepts the input beat this cycle.
- m_data  out  DATA_W  output beat (payload, then FCS chunks).
- m_valid  out  1  output beat valid.
- m_last  out  1  marks the final output beat of a frame.
- m_ready  in  1  downstream accepts the output beat.
- crc_state  out  32  running CRC register (pre-inversion).
- frame_done  out  1  one-cycle pulse after the s_last beat is accepted.
- fcs_ok  out  1  residue-check result; valid while frame_done=1.

Behaviour:
- CRC definition:
  - Reflected polynomial 0xEDB88320, register initialised to 0xFFFFFFFF.
  - Bits are processed LSB first; one beat = DATA_W sequential bit steps, computed combinationally as crc_next.
  - FCS = ~crc_next at the s_last beat, emitted LSB-first.
- Reset (rstn=0 at a clk edge):
  - Outputs: m_valid=0, m_last=0, m_data=0, frame_done=0, fcs_ok=0.
  - Internal: crc_state=0xFFFFFFFF, state=DATA, beat counter=0.
  - Reset mid-frame or mid-FCS aborts the frame with no further output beats.
- Output register: out_free = !m_valid || m_ready.
- State DATA:
  - s_ready = out_free.
  - On an input transfer (s_valid && s_ready):
    - m_data<=s_data, m_valid<=1, crc_state<=crc_next.
    - m_last<=s_last && !APPEND_FCS.
  - If the transfer has s_last:
    - crc_state<=0xFFFFFFFF (overrides crc_next), frame_done<=1.
    - fcs_ok<=(crc_next==0xDEBB20E3).
    - If APPEND_FCS: latch fcs_reg<=~crc_next, cnt<=0, go to FCS.
  - No input transfer but m_ready: m_valid<=0.
  - Latency: input beat to m_data is 1 cycle; no combinational path from s_data to m_data.
- State FCS (APPEND_FCS=1 only):
  - s_ready=0.
  - When out_free:
    - m_data<=fcs_reg[cnt*DATA_W +: DATA_W], m_valid<=1.
    - m_last<=(cnt==32/DATA_W-1), cnt<=cnt+1.
  - On the last chunk: go to DATA and clear cnt.
  - The next frame's first beat can be accepted the cycle after the last FCS chunk is loaded, if out_free.
- Backpressure:
  - m_ready=0 with m_valid=1 holds m_data, m_last and m_valid stable.
  - s_ready drops the same cycle; crc_state does not advance.
- frame_done: exactly one cycle high, irrespective of m_ready. fcs_ok holds until the next frame_done.
- Single-beat frames (s_last on the first beat) are legal.
- s_valid outside a transfer is ignored.
- crc_state is a register output, directly observable.

Test Plan:
- DATA_W=8, APPEND_FCS=1, bytes "123456789" (0x31..0x39), m_ready=1:
  - Required: 13 output beats = the 9 bytes then 0x26,0x39,0xF4,0xCB.
  - m_last only on 0xCB; frame_done pulses once; crc_state returns to 0xFFFFFFFF.
- DATA_W=4, same string as nibbles low-first:
  - Required: 18 payload nibbles then FCS nibbles 6,2,9,3,4,F,B,C; m_last on C.
- DATA_W=8, APPEND_FCS=0:
  - Input "123456789",0x26,0x39,0xF4,0xCB → frame_done with fcs_ok=1.
  - Flip bit 0 of the 0x35 byte → fcs_ok=0.
  - Output equals input beat-for-beat with m_last on the last byte.
- Backpressure, DATA_W=8, APPEND_FCS=1:
  - Stimulus: m_ready=0 for 3 cycles during payload beat 5, and for 2 cycles during FCS chunk 2.
  - Required: stream identical to the first test, m_data stable while stalled, s_ready=0 during stalls.
- Back-to-back frames:
  - Single byte 0x00 (s_last on beat 1) → output 0x00,0x8D,0xEF,0x02,0xD2.
  - Immediately followed by "123456789" → FCS 26 39 F4 CB, proving CRC re-initialisation.
- Reset mid-FCS:
  - Stimulus: assert rstn=0 for 1 cycle after the second FCS byte of frame 1.
  - Required: m_valid=0 and frame_done=0 after the edge; a following "123456789" frame yields FCS 26 39 F4 CB.
